dpc_ctrl: RTL and testbench

DPC_CTRL -- requirements
Module: dpc_ctrl

---
 rtl/dpc_pkg.sv | 28 ++
 rtl/dpc_if.sv | 32 +++
 rtl/dpc_pos_cnt.sv | 57 +++++
 rtl/dpc_ctrl.sv | 174 +++++++++++++++++
 tb/tb_dpc_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dpc_pkg.sv
// Shared definitions for the defect-pixel-correction controller and datapath:
// controller state encoding and helpers that derive sizes from the frame geometry.
package dpc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } dpc_state_e;

    // Bit width needed to hold values 0..n-1, never less than one bit.
    function automatic int cw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Shifts needed before the centre tap of the 5-line window holds pixel (0,0).
    function automatic int fill_len_f(input int h_disp);
        return 2 * h_disp + 3;
    endfunction

    // Padding shifts needed after the last input pixel to push it to the centre tap.
    function automatic int flush_len_f(input int h_disp);
        return 2 * h_disp + 2;
    endfunction

endpackage

// File: rtl/dpc_if.sv
// Pixel stream and window-control bundle between a pixel source, the controller
// and the window datapath.
interface dpc_if
    import dpc_pkg::*;
#(
    parameter int H_DISP = 720,
    parameter int V_DISP = 480
);
    localparam int CW = cw(H_DISP);
    localparam int RW = cw(V_DISP);

    logic          s_valid;
    logic          s_ready;
    logic          sft_en;
    logic          pad_sel;
    logic          win_valid;
    logic [CW-1:0] win_col;
    logic [RW-1:0] win_row;
    logic          win_bypass;

    // Pixel source / observer side.
    modport master (
        output s_valid,
        input  s_ready, sft_en, pad_sel, win_valid, win_col, win_row, win_bypass
    );

    // Controller side.
    modport slave (
        input  s_valid,
        output s_ready, sft_en, pad_sel, win_valid, win_col, win_row, win_bypass
    );
endinterface

// File: rtl/dpc_pos_cnt.sv
// Raster position counter: column runs 0..H_MAX-1, then wraps and advances the row;
// after the last pixel of the frame both wrap back to zero.
module dpc_pos_cnt
    import dpc_pkg::*;
#(
    parameter int H_MAX = 720,
    parameter int V_MAX = 480,
    parameter int CW    = cw(H_MAX),
    parameter int RW    = cw(V_MAX)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [CW-1:0] col_o,
    output logic [RW-1:0] row_o,
    output logic          col_wrap_o,
    output logic          frame_wrap_o
);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    assign col_wrap_o   = (col_q == CW'(H_MAX - 1));
    assign frame_wrap_o = col_wrap_o && (row_q == RW'(V_MAX - 1));
    assign col_o        = col_q;
    assign row_o        = row_q;

    // Next position: clear wins over increment; increment walks in raster order.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr_i) begin
            col_d = '0;
            row_d = '0;
        end else if (inc_i) begin
            if (col_wrap_o) begin
                col_d = '0;
                row_d = frame_wrap_o ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/dpc_ctrl.sv
// Frame sequencer for the defect-pixel-correction window: fills the line
// buffers, streams the frame, flushes with padding, and tags each centre pixel
// with its position and whether it must pass through uncorrected.
module dpc_ctrl
    import dpc_pkg::*;
#(
    parameter int H_DISP = 720,
    parameter int V_DISP = 480,
    parameter int BORDER = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    dpc_en_i,
    input  logic    frame_start_i,
    dpc_if.slave    bus,
    output logic    busy_o,
    output logic    frame_done_o,
    output logic    err_start_o
);

    localparam int CW        = cw(H_DISP);
    localparam int RW        = cw(V_DISP);
    localparam int FILL_LEN  = fill_len_f(H_DISP);
    localparam int FLUSH_LEN = flush_len_f(H_DISP);
    localparam int SW        = cw(FILL_LEN + 1);
    localparam int FW        = cw(FLUSH_LEN + 1);

    localparam logic [SW-1:0] FILL_SAT  = SW'(FILL_LEN);
    localparam logic [SW-1:0] FILL_LAST = SW'(FILL_LEN - 1);
    localparam logic [FW-1:0] FLUSH_END = FW'(FLUSH_LEN - 1);

    dpc_state_e    state_q, state_d;
    logic          en_q;
    logic          err_q;
    logic [SW-1:0] shift_q, shift_d;
    logic [FW-1:0] flush_q, flush_d;
    logic          win_valid_q, win_valid_d;
    logic          win_bypass_q, win_bypass_d;
    logic [CW-1:0] win_col_q;
    logic [RW-1:0] win_row_q;

    logic          start_acc;
    logic          accept;
    logic          s_ready;
    logic          sft_en;
    logic          pad_sel;

    logic [CW-1:0] in_col, wc_col;
    logic [RW-1:0] in_row, wc_row;
    logic          in_col_wrap, in_last;
    logic          wc_col_wrap, wc_last;
    logic          unused_pos;

    assign start_acc = frame_start_i && (state_q == ST_IDLE);
    assign accept    = bus.s_valid && s_ready;

    dpc_pos_cnt #(.H_MAX(H_DISP), .V_MAX(V_DISP), .CW(CW), .RW(RW)) u_in_cnt (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (start_acc),
        .inc_i        (accept),
        .col_o        (in_col),
        .row_o        (in_row),
        .col_wrap_o   (in_col_wrap),
        .frame_wrap_o (in_last)
    );

    dpc_pos_cnt #(.H_MAX(H_DISP), .V_MAX(V_DISP), .CW(CW), .RW(RW)) u_win_cnt (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (start_acc),
        .inc_i        (win_valid_d),
        .col_o        (wc_col),
        .row_o        (wc_row),
        .col_wrap_o   (wc_col_wrap),
        .frame_wrap_o (wc_last)
    );

    assign unused_pos = &{1'b0, in_col, in_row, in_col_wrap, wc_col_wrap, wc_last};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; the last input pixel ends the fill phase too on tiny frames.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (frame_start_i) state_d = ST_FILL;
            ST_FILL: begin
                if (accept) begin
                    if (in_last)                 state_d = ST_FLUSH;
                    else if (shift_q == FILL_LAST) state_d = ST_RUN;
                end
            end
            ST_RUN:   if (accept && in_last) state_d = ST_FLUSH;
            ST_FLUSH: if (flush_q == FLUSH_END) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the current state.
    always_comb begin
        s_ready      = (state_q == ST_FILL) || (state_q == ST_RUN);
        pad_sel      = (state_q == ST_FLUSH);
        sft_en       = (bus.s_valid && s_ready) || pad_sel;
        busy_o       = (state_q != ST_IDLE);
        frame_done_o = (state_q == ST_DONE);
    end

    // Shift and flush counting; the window is valid once the fill depth is reached.
    always_comb begin
        shift_d     = shift_q;
        flush_d     = flush_q;
        win_valid_d = sft_en && (shift_q >= FILL_LAST);
        if (start_acc) begin
            shift_d = '0;
            flush_d = '0;
        end else begin
            if (sft_en && (shift_q != FILL_SAT)) shift_d = shift_q + SW'(1);
            if (state_q == ST_FLUSH)             flush_d = flush_q + FW'(1);
        end
    end

    // Bypass decision for the pixel about to reach the centre tap.
    always_comb begin
        win_bypass_d = !en_q
                    || (int'(wc_col) <  BORDER)
                    || (int'(wc_col) >= H_DISP - BORDER)
                    || (int'(wc_row) <  BORDER)
                    || (int'(wc_row) >= V_DISP - BORDER);
    end

    // Counters, frame enable, error flag and the registered window tags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q      <= '0;
            flush_q      <= '0;
            en_q         <= 1'b0;
            err_q        <= 1'b0;
            win_valid_q  <= 1'b0;
            win_bypass_q <= 1'b0;
            win_col_q    <= '0;
            win_row_q    <= '0;
        end else begin
            shift_q     <= shift_d;
            flush_q     <= flush_d;
            win_valid_q <= win_valid_d;
            if (start_acc) en_q <= dpc_en_i;
            if (frame_start_i && (state_q != ST_IDLE)) err_q <= 1'b1;
            if (win_valid_d) begin
                win_col_q    <= wc_col;
                win_row_q    <= wc_row;
                win_bypass_q <= win_bypass_d;
            end
        end
    end

    assign bus.s_ready    = s_ready;
    assign bus.sft_en     = sft_en;
    assign bus.pad_sel    = pad_sel;
    assign bus.win_valid  = win_valid_q;
    assign bus.win_col    = win_col_q;
    assign bus.win_row    = win_row_q;
    assign bus.win_bypass = win_bypass_q;
    assign err_start_o    = err_q;

endmodule

// File: tb/tb_dpc_ctrl.sv
// Bench for dpc_ctrl: an 8x6 instance for the main scenarios and a 2x2 instance
// for the tiny-frame corner; window tags are compared with a raster model.
module tb_dpc_ctrl;

    localparam int H = 8;
    localparam int V = 6;
    localparam int B = 2;
    localparam int NPIX = H * V;

    typedef struct {
        int col;
        int row;
        bit byp;
    } winRec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dpcEn = 1'b0, frameStart = 1'b0;
    logic busy, frameDone, errStart;
    logic smallEn = 1'b0, smallStart = 1'b0;
    logic smallBusy, smallDone, smallErr;

    int total = 0;
    int bad = 0;

    winRec_t winQ[$];
    int accepts, pads, dones, sftBad, firstAcc, firstWin, padFirst, padLast, cyc;
    bit timedOut;

    dpc_if #(.H_DISP(H), .V_DISP(V)) bigBus ();
    dpc_if #(.H_DISP(2), .V_DISP(2)) smallBus ();

    dpc_ctrl #(.H_DISP(H), .V_DISP(V), .BORDER(B)) dut (
        .clk           (clk),
        .rst           (rst),
        .dpc_en_i      (dpcEn),
        .frame_start_i (frameStart),
        .bus           (bigBus),
        .busy_o        (busy),
        .frame_done_o  (frameDone),
        .err_start_o   (errStart)
    );

    dpc_ctrl #(.H_DISP(2), .V_DISP(2), .BORDER(0)) dutSmall (
        .clk           (clk),
        .rst           (rst),
        .dpc_en_i      (smallEn),
        .frame_start_i (smallStart),
        .bus           (smallBus),
        .busy_o        (smallBusy),
        .frame_done_o  (smallDone),
        .err_start_o   (smallErr)
    );

    always #5 clk = ~clk;

    // Reference rule: a pixel passes uncorrected if correction is off or it lies near an edge.
    function automatic bit expByp(int h, int v, int b, bit en, int col, int row);
        return !en || (col < b) || (col >= h - b) || (row < b) || (row >= v - b);
    endfunction

    // Drive one frame into the 8x6 instance and record what it produces.
    // mode 0: continuous s_valid, 1: alternating, 2: random.
    task automatic runFrame(input bit en, input int mode, input bit toggleEn, input bit midStart);
        bit startPulsed = 0;
        winQ.delete();
        accepts = 0; pads = 0; dones = 0; sftBad = 0;
        firstAcc = -1; firstWin = -1; padFirst = -1; padLast = -1; timedOut = 0;
        dpcEn = en; frameStart = 1'b1; bigBus.s_valid = 1'b0;
        @(posedge clk); #1;
        frameStart = 1'b0;
        cyc = 0;
        for (int g = 0; g < 3000 && dones == 0; g++) begin
            case (mode)
                0:       bigBus.s_valid = 1'b1;
                1:       bigBus.s_valid = (cyc % 2 == 0);
                default: bigBus.s_valid = ($urandom_range(0, 3) != 0);
            endcase
            if (toggleEn) dpcEn = ~dpcEn;
            if (midStart && !startPulsed && accepts == 30) begin
                frameStart = 1'b1;
                startPulsed = 1;
            end else begin
                frameStart = 1'b0;
            end
            @(negedge clk);
            if (bigBus.s_valid && bigBus.s_ready) begin
                accepts++;
                if (firstAcc < 0) firstAcc = cyc;
            end
            if ((bigBus.sft_en && !bigBus.pad_sel) !== (bigBus.s_valid && bigBus.s_ready)) sftBad++;
            if (bigBus.pad_sel) begin
                pads++;
                if (padFirst < 0) padFirst = cyc;
                padLast = cyc;
                if (!bigBus.sft_en) sftBad++;
            end
            if (bigBus.win_valid) begin
                winQ.push_back('{int'(bigBus.win_col), int'(bigBus.win_row), bigBus.win_bypass});
                if (firstWin < 0) firstWin = cyc;
            end
            if (frameDone) dones++;
            @(posedge clk); #1;
            cyc++;
        end
        bigBus.s_valid = 1'b0;
        frameStart = 1'b0;
        if (dones == 0) timedOut = 1;
    endtask

    // Reset state, and s_valid while idle must not be taken.
    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        total++; if (bigBus.win_valid !== 1'b0 || bigBus.win_bypass !== 1'b0) begin bad++;
            $display("[TB] FAIL reset_win got valid=%b byp=%b want 0/0", bigBus.win_valid, bigBus.win_bypass); end
        total++; if (bigBus.win_col !== 3'd0 || bigBus.win_row !== 3'd0) begin bad++;
            $display("[TB] FAIL reset_pos got=(%0d,%0d) want=(0,0)", bigBus.win_col, bigBus.win_row); end
        total++; if (frameDone !== 1'b0 || errStart !== 1'b0) begin bad++;
            $display("[TB] FAIL reset_flags got done=%b err=%b want 0/0", frameDone, errStart); end
        @(posedge clk); #1;
        rst = 1'b0;
        bigBus.s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (bigBus.s_ready !== 1'b0 || bigBus.sft_en !== 1'b0 || busy !== 1'b0) begin bad++;
                $display("[TB] FAIL idle_accept got ready=%b sft=%b busy=%b want 0/0/0",
                         bigBus.s_ready, bigBus.sft_en, busy); end
        end
        @(posedge clk); #1;
        bigBus.s_valid = 1'b0;
    endtask

    // Continuous stream: latency, pulse count, raster order, flush length.
    task automatic test_continuous();
        int errs = 0;
        runFrame(1'b1, 0, 1'b0, 1'b0);
        total++; if (timedOut) begin bad++; $display("[TB] FAIL cont_timeout got=no_done want=done"); end
        total++; if (winQ.size() !== NPIX) begin bad++; $display("[TB] FAIL cont_count got=%0d want=%0d", winQ.size(), NPIX); end
        total++; if (firstWin - firstAcc !== 19) begin bad++; $display("[TB] FAIL cont_latency got=%0d want=19", firstWin - firstAcc); end
        total++; if (winQ.size() == 0 || winQ[0].col !== 0 || winQ[0].row !== 0 || winQ[0].byp !== 1'b1) begin bad++;
            $display("[TB] FAIL cont_first got size=%0d want (0,0) bypass=1", winQ.size()); end
        foreach (winQ[i]) begin
            if (winQ[i].col !== i % H || winQ[i].row !== i / H || winQ[i].byp !== expByp(H, V, B, 1'b1, i % H, i / H)) errs++;
        end
        total++; if (errs !== 0) begin bad++; $display("[TB] FAIL cont_coords got=%0d bad entries want=0", errs); end
        total++; if (pads !== 18 || padLast - padFirst + 1 !== 18) begin bad++;
            $display("[TB] FAIL cont_flush got=%0d pads span=%0d want=18", pads, padLast - padFirst + 1); end
        total++; if (dones !== 1) begin bad++; $display("[TB] FAIL cont_done got=%0d want=1", dones); end
        total++; if (accepts !== NPIX || sftBad !== 0) begin bad++;
            $display("[TB] FAIL cont_shift got acc=%0d sftbad=%0d want %0d/0", accepts, sftBad, NPIX); end
        @(negedge clk);
        total++; if (busy !== 1'b0 || errStart !== 1'b0) begin bad++;
            $display("[TB] FAIL cont_idle got busy=%b err=%b want 0/0", busy, errStart); end
    endtask

    // Alternating s_valid stalls the frame without changing its content.
    task automatic test_stall();
        int errs = 0;
        runFrame(1'b1, 1, 1'b0, 1'b0);
        total++; if (winQ.size() !== NPIX) begin bad++; $display("[TB] FAIL stall_count got=%0d want=%0d", winQ.size(), NPIX); end
        foreach (winQ[i]) begin
            if (winQ[i].col !== i % H || winQ[i].row !== i / H || winQ[i].byp !== expByp(H, V, B, 1'b1, i % H, i / H)) errs++;
        end
        total++; if (errs !== 0) begin bad++; $display("[TB] FAIL stall_coords got=%0d bad entries want=0", errs); end
        total++; if (sftBad !== 0 || accepts !== NPIX) begin bad++;
            $display("[TB] FAIL stall_shift got sftbad=%0d acc=%0d want 0/%0d", sftBad, accepts, NPIX); end
        total++; if (dones !== 1) begin bad++; $display("[TB] FAIL stall_done got=%0d want=1", dones); end
    endtask

    // Enable off bypasses everything; toggling enable mid-frame is ignored.
    task automatic test_enable();
        int errs = 0;
        int corrected = 0;
        runFrame(1'b0, 2, 1'b0, 1'b0);
        foreach (winQ[i]) begin
            if (winQ[i].byp !== expByp(H, V, B, 1'b0, i % H, i / H)) errs++;
            if (!winQ[i].byp) corrected++;
        end
        total++; if (winQ.size() !== NPIX || errs !== 0 || corrected !== 0) begin bad++;
            $display("[TB] FAIL en_off got size=%0d errs=%0d corrected=%0d want %0d/0/0", winQ.size(), errs, corrected, NPIX); end
        errs = 0; corrected = 0;
        runFrame(1'b1, 2, 1'b1, 1'b0);
        foreach (winQ[i]) begin
            if (winQ[i].col !== i % H || winQ[i].row !== i / H || winQ[i].byp !== expByp(H, V, B, 1'b1, i % H, i / H)) errs++;
            if (!winQ[i].byp) corrected++;
        end
        total++; if (winQ.size() !== NPIX || errs !== 0) begin bad++;
            $display("[TB] FAIL en_toggle got size=%0d errs=%0d want %0d/0", winQ.size(), errs, NPIX); end
        total++; if (corrected !== 8) begin bad++; $display("[TB] FAIL en_corrected got=%0d want=8", corrected); end
    endtask

    // frame_start during RUN flags an error but the frame and the next one run clean.
    task automatic test_back_to_back();
        int errs = 0;
        runFrame(1'b1, 0, 1'b0, 1'b1);
        total++; if (errStart !== 1'b1) begin bad++; $display("[TB] FAIL b2b_err got=%b want=1", errStart); end
        foreach (winQ[i]) begin
            if (winQ[i].col !== i % H || winQ[i].row !== i / H || winQ[i].byp !== expByp(H, V, B, 1'b1, i % H, i / H)) errs++;
        end
        total++; if (winQ.size() !== NPIX || errs !== 0 || dones !== 1 || pads !== 18) begin bad++;
            $display("[TB] FAIL b2b_frame got size=%0d errs=%0d done=%0d pads=%0d want %0d/0/1/18", winQ.size(), errs, dones, pads, NPIX); end
        errs = 0;
        runFrame(1'b1, 2, 1'b0, 1'b0);
        foreach (winQ[i]) begin
            if (winQ[i].col !== i % H || winQ[i].row !== i / H || winQ[i].byp !== expByp(H, V, B, 1'b1, i % H, i / H)) errs++;
        end
        total++; if (winQ.size() !== NPIX || errs !== 0 || dones !== 1) begin bad++;
            $display("[TB] FAIL b2b_second got size=%0d errs=%0d done=%0d want %0d/0/1", winQ.size(), errs, dones, NPIX); end
        total++; if (errStart !== 1'b1) begin bad++; $display("[TB] FAIL b2b_sticky got=%b want=1", errStart); end
    endtask

    // Reset in FLUSH aborts the frame silently; a later frame is clean.
    task automatic test_reset_flush();
        int seen = 0;
        int errs = 0;
        int strayDone = 0;
        dpcEn = 1'b1; frameStart = 1'b1;
        @(posedge clk); #1;
        frameStart = 1'b0;
        bigBus.s_valid = 1'b1;
        for (int g = 0; g < 300 && seen < 5; g++) begin
            @(negedge clk);
            if (bigBus.pad_sel) seen++;
            @(posedge clk); #1;
        end
        total++; if (seen !== 5) begin bad++; $display("[TB] FAIL rstfl_reach got=%0d pads want=5", seen); end
        rst = 1'b1;
        @(negedge clk);
        total++; if ({busy, bigBus.s_ready, bigBus.sft_en, bigBus.pad_sel, bigBus.win_valid, bigBus.win_bypass, frameDone, errStart} !== 8'd0) begin bad++;
            $display("[TB] FAIL rstfl_outs got busy=%b rdy=%b sft=%b pad=%b wv=%b byp=%b done=%b err=%b want all 0",
                     busy, bigBus.s_ready, bigBus.sft_en, bigBus.pad_sel, bigBus.win_valid, bigBus.win_bypass, frameDone, errStart); end
        total++; if (bigBus.win_col !== 3'd0 || bigBus.win_row !== 3'd0) begin bad++;
            $display("[TB] FAIL rstfl_pos got=(%0d,%0d) want=(0,0)", bigBus.win_col, bigBus.win_row); end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (frameDone || busy) strayDone++;
            @(posedge clk); #1;
        end
        total++; if (strayDone !== 0) begin bad++; $display("[TB] FAIL rstfl_nodone got=%0d want=0", strayDone); end
        bigBus.s_valid = 1'b0;
        runFrame(1'b1, 0, 1'b0, 1'b0);
        foreach (winQ[i]) begin
            if (winQ[i].col !== i % H || winQ[i].row !== i / H || winQ[i].byp !== expByp(H, V, B, 1'b1, i % H, i / H)) errs++;
        end
        total++; if (winQ.size() !== NPIX || errs !== 0 || dones !== 1 || firstWin - firstAcc !== 19) begin bad++;
            $display("[TB] FAIL rstfl_after got size=%0d errs=%0d done=%0d lat=%0d want %0d/0/1/19",
                     winQ.size(), errs, dones, firstWin - firstAcc, NPIX); end
    endtask

    // 2x2 frame: the fill depth exceeds the frame, so input ends straight into flush.
    task automatic test_small();
        winRec_t sQ[$];
        int sAcc = 0, sPads = 0, sDone = 0, sLastAcc = -1, sPadFirst = -1, errs = 0;
        smallEn = 1'b1; smallStart = 1'b1; smallBus.s_valid = 1'b0;
        @(posedge clk); #1;
        smallStart = 1'b0;
        for (int c = 0; c < 200 && sDone == 0; c++) begin
            smallBus.s_valid = 1'b1;
            @(negedge clk);
            if (smallBus.s_valid && smallBus.s_ready) begin sAcc++; sLastAcc = c; end
            if (smallBus.pad_sel) begin sPads++; if (sPadFirst < 0) sPadFirst = c; end
            if (smallBus.win_valid) sQ.push_back('{int'(smallBus.win_col), int'(smallBus.win_row), smallBus.win_bypass});
            if (smallDone) sDone++;
            @(posedge clk); #1;
        end
        smallBus.s_valid = 1'b0;
        total++; if (sAcc !== 4 || sPadFirst !== sLastAcc + 1) begin bad++;
            $display("[TB] FAIL small_direct got acc=%0d lastacc=%0d padfirst=%0d want 4 and pad right after", sAcc, sLastAcc, sPadFirst); end
        total++; if (sPads !== 6) begin bad++; $display("[TB] FAIL small_flush got=%0d want=6", sPads); end
        foreach (sQ[i]) begin
            if (sQ[i].col !== i % 2 || sQ[i].row !== i / 2 || sQ[i].byp !== expByp(2, 2, 0, 1'b1, i % 2, i / 2)) errs++;
        end
        total++; if (sQ.size() !== 4 || errs !== 0) begin bad++;
            $display("[TB] FAIL small_win got size=%0d errs=%0d want 4/0", sQ.size(), errs); end
        total++; if (sDone !== 1 || smallErr !== 1'b0) begin bad++;
            $display("[TB] FAIL small_done got done=%0d err=%b want 1/0", sDone, smallErr); end
    endtask

    initial begin
        bigBus.s_valid = 1'b0;
        smallBus.s_valid = 1'b0;
        $display("[TB] starting dpc_ctrl bench");
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_continuous();
        test_stall();
        test_enable();
        test_back_to_back();
        test_reset_flush();
        test_small();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
